// File: rtl/uart_prot_trig.sv
// uart_prot_trig: UART protocol trigger for the logic analyzer.
// Receives 8N1 frames on RX at a programmable bit period. When a frame arrives
// with a valid stop bit and its byte equals 'match' on every bit that 'mask'
// does not ignore, UARTtrig pulses high for one cycle.
//
// Ports:
//   clk      - system clock
//   rst      - synchronous, active-high reset
//   RX       - asynchronous serial input, idle high
//   baud_cnt - bit period in clk cycles, latched at start-bit detect (min 4)
//   match    - byte value to trigger on
//   mask     - per-bit don't-care (1 = ignore bit)
//   UARTtrig - one-cycle pulse on a matching, well-framed byte
//   busy     - high while a frame is being received
module uart_prot_trig #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  input  logic [15:0] baud_cnt,
  input  logic [7:0]  match,
  input  logic [7:0]  mask,
  output logic        UARTtrig,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StRecv, StCheck} state_e;

  state_e                 r_state, w_state_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rx_prev;
  logic [15:0]            r_per;
  logic [15:0]            r_cnt;
  logic [3:0]             r_idx;
  logic [7:0]             r_shift;
  logic                   r_stop;
  logic                   r_trig;

  logic        w_rx_s;
  logic        w_start;
  logic        w_tick;
  logic [15:0] w_per_in;
  logic        w_match_ok;

  assign w_rx_s     = r_sync[SYNC_STAGES-1];
  assign w_start    = (r_state == StIdle) && r_rx_prev && !w_rx_s;
  assign w_tick     = (r_state == StRecv) && (r_cnt == 16'd0);
  // Periods below 4 leave no room for a mid-bit sample; clamp them.
  assign w_per_in   = (baud_cnt < 16'd4) ? 16'd4 : baud_cnt;
  assign w_match_ok = r_stop && ((r_shift | mask) == (match | mask));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_start) w_state_next = StRecv;
      end
      StRecv: begin
        if (w_tick) begin
          // A start bit that is high again at mid-bit was a glitch.
          if ((r_idx == 4'd0) && w_rx_s) w_state_next = StIdle;
          else if (r_idx == 4'd9)         w_state_next = StCheck;
        end
      end
      StCheck: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    busy     = (r_state != StIdle);
    UARTtrig = r_trig;
  end

  // Synchronizer, bit timing and data path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync    <= '1;
      r_rx_prev <= 1'b1;
      r_per     <= 16'd0;
      r_cnt     <= 16'd0;
      r_idx     <= 4'd0;
      r_shift   <= 8'h00;
      r_stop    <= 1'b0;
      r_trig    <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], RX};
      r_rx_prev <= w_rx_s;
      r_trig    <= (r_state == StCheck) && w_match_ok;
      if (w_start) begin
        r_per <= w_per_in;
        r_cnt <= w_per_in >> 1;
        r_idx <= 4'd0;
      end else if (r_state == StRecv) begin
        if (w_tick) begin
          r_cnt <= r_per - 16'd1;
          r_idx <= r_idx + 4'd1;
          // Data arrives LSB first: shift in at the top, so after 8 bits
          // the first one sits in bit 0.
          if ((r_idx >= 4'd1) && (r_idx <= 4'd8)) r_shift <= {w_rx_s, r_shift[7:1]};
          // Stop sample is held so RX activity during CHECK cannot matter.
          if (r_idx == 4'd9) r_stop <= w_rx_s;
        end else begin
          r_cnt <= r_cnt - 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_prot_trig.sv
module tb_uart_prot_trig;

  logic        clk = 1'b0;
  logic        rst;
  logic        RX;
  logic [15:0] baud_cnt;
  logic [7:0]  match;
  logic [7:0]  mask;
  logic        UARTtrig;
  logic        busy;

  always #5 clk = ~clk;

  uart_prot_trig #(
    .SYNC_STAGES(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .RX      (RX),
    .baud_cnt(baud_cnt),
    .match   (match),
    .mask    (mask),
    .UARTtrig(UARTtrig),
    .busy    (busy)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  int          n_trig = 0;
  int          n_wide = 0;
  logic        prev_trig = 1'b0;
  logic        prev_busy = 1'b0;
  logic        busy_at_trig = 1'b1;
  logic        busy_before_trig = 1'b0;
  int unsigned trig_q[$];

  always @(negedge clk) begin
    if (UARTtrig === 1'b1) begin
      n_trig++;
      trig_q.push_back(cyc);
      busy_at_trig     = busy;
      busy_before_trig = prev_busy;
      if (prev_trig) n_wide++;
    end
    prev_trig = (UARTtrig === 1'b1);
    prev_busy = busy;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one 8N1 frame starting at the current falling edge; s = start cycle.
  // If rst_bit >= 0, pulse rst for one cycle in the middle of that bit slot.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int per,
                            input int rst_bit, output int unsigned s);
    logic [9:0] bits;
    bits = {stop_bit, data, 1'b0};
    s    = cyc;
    for (int k = 0; k < 10; k++) begin
      RX = bits[k];
      for (int j = 0; j < per; j++) begin
        if (k == rst_bit && j == per / 2) begin
          check_eq("busy_before_rst", {31'd0, busy}, 32'd1);
          rst = 1'b1;
        end
        @(negedge clk);
        if (rst) begin
          rst = 1'b0;
          check_eq("busy_after_rst", {31'd0, busy}, 32'd0);
          check_eq("trig_after_rst", {31'd0, UARTtrig}, 32'd0);
        end
      end
    end
    RX = 1'b1;
  endtask

  function automatic int unsigned first_lat(input int unsigned s);
    return (trig_q.size() > 0) ? trig_q[0] - s : 32'hFFFF_FFFF;
  endfunction

  int          n0;
  int unsigned s;
  int unsigned s2;

  initial begin
    rst      = 1'b1;
    RX       = 1'b1;
    baud_cnt = 16'd868;
    match    = 8'h96;
    mask     = 8'h00;
    idle(3);
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    check_eq("reset_trig", {31'd0, UARTtrig}, 32'd0);
    rst = 1'b0;
    idle(5);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);

    // Matching byte at 868: sample 9 at s+4+434+9*868, pulse one cycle later.
    n0 = n_trig;
    trig_q.delete();
    send_frame(8'h96, 1'b1, 868, -1, s);
    idle(50);
    check_eq("t1_count", n_trig - n0, 32'd1);
    check_eq("t1_latency", first_lat(s), 32'd8251);
    check_eq("t1_width", n_wide, 32'd0);
    check_eq("t1_busy_at_trig", {31'd0, busy_at_trig}, 32'd0);
    check_eq("t1_busy_before_trig", {31'd0, busy_before_trig}, 32'd1);

    // Non-matching byte.
    n0 = n_trig;
    send_frame(8'h97, 1'b1, 868, -1, s);
    idle(50);
    check_eq("t2_count", n_trig - n0, 32'd0);
    check_eq("t2_busy", {31'd0, busy}, 32'd0);

    // Masked compares at a short period (16): latency 5+8+9*16.
    baud_cnt = 16'd16;
    match    = 8'h90;
    mask     = 8'h0F;
    n0 = n_trig;
    trig_q.delete();
    send_frame(8'h96, 1'b1, 16, -1, s);
    idle(50);
    check_eq("t3_mask_hit", n_trig - n0, 32'd1);
    check_eq("t3_latency", first_lat(s), 32'd157);
    match = 8'hA6;
    n0 = n_trig;
    send_frame(8'h96, 1'b1, 16, -1, s);
    idle(50);
    check_eq("t3_mask_miss", n_trig - n0, 32'd0);
    match = 8'h00;
    mask  = 8'hFF;
    n0 = n_trig;
    send_frame(8'h3C, 1'b1, 16, -1, s);
    idle(50);
    check_eq("t3_mask_all", n_trig - n0, 32'd1);

    // Glitch start: low for 100 cycles, rejected at the half-bit sample.
    baud_cnt = 16'd868;
    match    = 8'h96;
    mask     = 8'h00;
    n0 = n_trig;
    RX = 1'b0;
    idle(100);
    RX = 1'b1;
    check_eq("t4_busy_during", {31'd0, busy}, 32'd1);
    idle(400);
    check_eq("t4_busy_after", {31'd0, busy}, 32'd0);
    check_eq("t4_no_trig", n_trig - n0, 32'd0);
    n0 = n_trig;
    send_frame(8'h96, 1'b1, 868, -1, s);
    idle(50);
    check_eq("t4_valid_after", n_trig - n0, 32'd1);

    // Framing error, then two back-to-back frames.
    baud_cnt = 16'd64;
    n0 = n_trig;
    send_frame(8'h96, 1'b0, 64, -1, s);
    idle(100);
    check_eq("t5_bad_stop", n_trig - n0, 32'd0);
    check_eq("t5_bad_busy", {31'd0, busy}, 32'd0);
    baud_cnt = 16'd868;
    n0 = n_trig;
    trig_q.delete();
    send_frame(8'h96, 1'b1, 868, -1, s);
    send_frame(8'h96, 1'b1, 868, -1, s2);
    idle(50);
    check_eq("t5_b2b_count", n_trig - n0, 32'd2);
    check_eq("t5_b2b_spacing", (trig_q.size() > 1) ? trig_q[1] - trig_q[0] : 32'd0, 32'd8680);

    // Reset in the middle of data bit 4; the rest of the line then looks like
    // a misaligned frame (byte 0xFE), which must not trigger either.
    n0 = n_trig;
    send_frame(8'h96, 1'b1, 868, 5, s);
    idle(6 * 868);
    check_eq("t6_no_trig", n_trig - n0, 32'd0);
    check_eq("t6_busy_idle", {31'd0, busy}, 32'd0);

    // baud_cnt=2 is clamped to 4: latency 5+2+9*4.
    baud_cnt = 16'd2;
    n0 = n_trig;
    trig_q.delete();
    send_frame(8'h96, 1'b1, 4, -1, s);
    idle(50);
    check_eq("t6_clamp_count", n_trig - n0, 32'd1);
    check_eq("t6_clamp_latency", first_lat(s), 32'd43);
    check_eq("final_width", n_wide, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_prot_trig.md
Name: uart_prot_trig

Overview:
Protocol-trigger stage for the logic analyzer. Watches one captured channel line (CH1, driven by a UART source in protocol-trigger tests) and receives 8N1 UART frames at a programmable bit period. When a received byte equals a programmed match value under a don't-care mask, it emits a one-cycle trigger pulse. The pulse is consumed by the trigger logic in LA_dig.

Parameters:
SYNC_STAGES, 2, number of flops in the RX metastability synchronizer (must be ≥2).

Ports:
clk  input  1  system clock (100 MHz main clock).
rst  input  1  synchronous, active-high reset.
RX  input  1  asynchronous serial line under test (CH1 data); idle high.
baud_cnt  input  16  bit period in clk cycles. Latched at start-bit detect.
match  input  8  byte value to trigger on.
mask  input  8  per-bit don't-care; 1 = ignore that bit in the compare.
UARTtrig  output  1  one-cycle pulse on a matching, well-framed byte.
busy  output  1  high while a frame is being received.

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high (rst).
- Reset values:
  - UARTtrig=0, busy=0, state=IDLE.
  - All synchronizer flops = 1; shift register = 8'h00; counters = 0.
- RX passes through SYNC_STAGES flops. rx_s is the last stage; rx_prev is rx_s delayed by one cycle.
- Start-bit detect: rx_prev=1 && rx_s=0 while in IDLE.
- Bit-period latch: at start detect, baud_cnt is latched into per_q, with values <4 clamped to 4. Later baud_cnt changes do not affect the frame in progress.
- States:
  - IDLE: busy=0. On start detect → RECV. Load bit counter = per_q>>1 (half-bit) and bit index = 0.
  - RECV: busy=1. Bit counter decrements every clk. When it reaches 0, sample rx_s, reload per_q−1, and increment the index.
    - Index 0 (start bit): if rx_s=1, the start was a glitch → IDLE, no trigger.
    - Index 1..8: shift rx_s in LSB first.
    - Index 9 (stop bit) → CHECK.
  - CHECK: one cycle, then → IDLE.
    - Fire when stop sample = 1 and (byte | mask) == (match | mask).
    - UARTtrig is registered, so it is high in the cycle after CHECK, for exactly one cycle.
- Sample timing: sample k falls per_q>>1 + k·per_q cycles after start detect, for k = 0..9.
- End of frame: in the cycle after CHECK, state is IDLE. A falling edge seen then begins the next frame, so back-to-back frames with a 1-bit stop are supported.
- Framing error (stop sample 0): no trigger; return to IDLE. A frame start is not accepted while rx_s=0; the next frame requires a 1→0 transition.
- Mask 8'hFF: any well-framed byte triggers.
- rst asserted mid-frame: next cycle state=IDLE, busy=0, UARTtrig=0. A partial byte never triggers.
- RX changing during CHECK has no effect on the current result.

Test Plan:
1. baud_cnt=868, match=8'h96, mask=8'h00; UART_tx sends 8'h96 → exactly one UARTtrig pulse, 1 cycle wide. It occurs 1 cycle after the stop sample, ≈434+9·868+1 cycles after the synced falling edge. busy falls on the same cycle.
2. Same setup, send 8'h97 → UARTtrig stays 0 for the whole frame; busy returns to 0.
3. match=8'h90, mask=8'h0F; send 8'h96 → one trigger. Then match=8'hA6, mask=8'h0F; send 8'h96 → no trigger.
4. Force RX low for 100 cycles, then high (glitch start, baud_cnt=868) → at the half-bit sample the start is rejected; busy drops; no trigger. A following valid 8'h96 frame still triggers.
5. Drive a hand-built frame for 8'h96 with stop bit = 0, then idle high → no trigger. Then send two back-to-back valid 8'h96 frames → two pulses spaced 10·868 cycles apart.
6. Assert rst for 1 cycle in the middle of data bit 4 of a matching frame → busy=0 the next cycle, no trigger for that frame. A subsequent frame triggers normally. baud_cnt=2 behaves as 4 (samples at 2+4k cycles).
